// File: rtl/lock_pkg.sv
// lock_pkg: constants and state encodings shared by the button front-end and the lock FSM
package lock_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    typedef enum logic [2:0] {
        LOCK_IDLE,
        LOCK_GOT1,
        LOCK_GOT2,
        LOCK_GOT3,
        LOCK_OPEN
    } lock_state_t;

endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// debounce_cell: polarity fix, 2-flop synchroniser, debounce counter and press detect for one button
module debounce_cell
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES),
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset_in,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 pressed;
    logic                 s1;
    logic                 s2;
    logic [CNT_WIDTH-1:0] cnt;

    assign pressed = BTN_ACTIVE_LOW ? ~raw : raw;

    // bring the asynchronous pin into the clock domain
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pressed;
            s2 <= s1;
        end
    end

    // accept a new level only after it has held for DEBOUNCE_CYCLES consecutive edges
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign rise = s2 & ~stable & (cnt == CNT_MAX);

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces two raw buttons and emits mutually exclusive single-cycle press pulses
module button_conditioner
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES),
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset_in,
    input  logic b0_raw,
    input  logic b1_raw,
    output logic b0_out,
    output logic b1_out,
    output logic b0_level,
    output logic b1_level
);

    logic rise0;
    logic rise1;
    logic b1_pend;

    debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_cell0 (
        .clk     (clk),
        .reset_in(reset_in),
        .raw     (b0_raw),
        .stable  (b0_level),
        .rise    (rise0)
    );

    debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_cell1 (
        .clk     (clk),
        .reset_in(reset_in),
        .raw     (b1_raw),
        .stable  (b1_level),
        .rise    (rise1)
    );

    // b0 wins a collision; the losing b1 press is held one cycle and issued next
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            b0_out  <= 1'b0;
            b1_out  <= 1'b0;
            b1_pend <= 1'b0;
        end else begin
            b0_out  <= rise0;
            b1_out  <= ~rise0 & (b1_pend | rise1);
            b1_pend <= rise0 & (b1_pend | rise1);
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: window-based reference model feeding a pulse scoreboard, with directed and random phases
module tb_button_conditioner;

    localparam int DB = 4;

    logic clk;
    logic reset_in;
    logic b0_raw;
    logic b1_raw;
    logic b0_out;
    logic b1_out;
    logic b0_level;
    logic b1_level;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .BTN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk     (clk),
        .reset_in(reset_in),
        .b0_raw  (b0_raw),
        .b1_raw  (b1_raw),
        .b0_out  (b0_out),
        .b1_out  (b1_out),
        .b0_level(b0_level),
        .b1_level(b1_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    int          q0[$];
    int          q1[$];
    logic [DB-1:0] w [2];
    bit          lvl [2];
    bit          raw_d1 [2];
    bit          raw_d2 [2];
    bit          rst_d1;
    bit          rst_d2;

    int          req_n = 0;
    int          done_n = 0;
    int          exp_p0;
    int          exp_p1;
    string       phase_name;
    bit          finish_req = 1'b0;
    int          p0 = 0;
    int          p1 = 0;

    initial begin
        w[0] = '0;
        w[1] = '0;
    end

    // reference model: a level is accepted once the last DB synchronised samples all disagree with it
    always @(posedge clk) begin
        bit r;
        bit sy;
        bit rs [2];
        bit raw_now [2];
        r = !reset_in;
        raw_now[0] = b0_raw;
        raw_now[1] = b1_raw;
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            sy = (r || rst_d1 || rst_d2) ? 1'b0 : raw_d2[i];
            w[i] = {w[i][DB-2:0], sy};
            rs[i] = 1'b0;
            if (r) lvl[i] = 1'b0;
            else if (w[i] == {DB{!lvl[i]}}) begin
                rs[i] = !lvl[i];
                lvl[i] = !lvl[i];
            end
            raw_d2[i] = raw_d1[i];
            raw_d1[i] = raw_now[i];
        end
        rst_d2 = rst_d1;
        rst_d1 = r;
        if (r && q1.size() != 0 && q1[$] == edge_n) void'(q1.pop_back());
        if (rs[0]) q0.push_back(edge_n);
        if (rs[1]) q1.push_back(edge_n + (rs[0] ? 1 : 0));
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    // monitor: compares DUT outputs against the scoreboard just after each edge
    always @(posedge clk) begin
        int e;
        #1;
        check(!(b0_out && b1_out), "exclusive", {b0_out, b1_out}, 0);
        check(b0_level == lvl[0], "b0_level", b0_level, lvl[0]);
        check(b1_level == lvl[1], "b1_level", b1_level, lvl[1]);
        if (b0_out) begin
            p0++;
            if (q0.size() == 0) check(1'b0, "b0_out unexpected", edge_n, -1);
            else begin
                e = q0.pop_front();
                check(e == edge_n, "b0_out edge", edge_n, e);
            end
        end
        if (b1_out) begin
            p1++;
            if (q1.size() == 0) check(1'b0, "b1_out unexpected", edge_n, -1);
            else begin
                e = q1.pop_front();
                check(e == edge_n, "b1_out edge", edge_n, e);
            end
        end
        if (q0.size() != 0 && q0[0] < edge_n) begin
            e = q0.pop_front();
            check(1'b0, "b0_out missing", edge_n, e);
        end
        if (q1.size() != 0 && q1[0] < edge_n) begin
            e = q1.pop_front();
            check(1'b0, "b1_out missing", edge_n, e);
        end
        if (req_n != done_n) begin
            done_n = req_n;
            check(p0 == exp_p0, {phase_name, " b0 pulses"}, p0, exp_p0);
            check(p1 == exp_p1, {phase_name, " b1 pulses"}, p1, exp_p1);
            p0 = 0;
            p1 = 0;
        end
        if (finish_req) begin
            check(q0.size() == 0, "b0 pending at end", q0.size(), 0);
            check(q1.size() == 0, "b1 pending at end", q1.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulses(input string name, input int e0, input int e1);
        phase_name = name;
        exp_p0 = e0;
        exp_p1 = e1;
        req_n++;
        idle(2);
    endtask

    initial begin
        reset_in = 1'b0;
        b0_raw = 1'b1;
        b1_raw = 1'b1;
        idle(3);
        reset_in = 1'b1;
        idle(12);
        b0_raw = 1'b0;
        b1_raw = 1'b0;
        idle(12);
        expect_pulses("held_through_reset", 1, 1);

        b0_raw = 1'b1;
        idle(20);
        b0_raw = 1'b0;
        idle(12);
        expect_pulses("single_press", 1, 0);

        for (int n = 0; n < 16; n++) begin
            b1_raw = (n % 4) < 2;
            idle(1);
        end
        b1_raw = 1'b0;
        idle(12);
        expect_pulses("bounce", 0, 0);

        b0_raw = 1'b1;
        b1_raw = 1'b1;
        idle(10);
        b0_raw = 1'b0;
        b1_raw = 1'b0;
        idle(12);
        expect_pulses("collision", 1, 1);

        b0_raw = 1'b1;
        idle(8);
        b0_raw = 1'b0;
        idle(10);
        b0_raw = 1'b1;
        idle(8);
        b0_raw = 1'b0;
        idle(12);
        expect_pulses("repress", 2, 0);

        b0_raw = 1'b1;
        idle(4);
        reset_in = 1'b0;
        idle(1);
        reset_in = 1'b1;
        idle(10);
        b0_raw = 1'b0;
        idle(12);
        expect_pulses("reset_midcount", 1, 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) b0_raw = !b0_raw;
            if ($urandom_range(0, 5) == 0) b1_raw = !b1_raw;
            reset_in = ($urandom_range(0, 99) != 0);
            idle(1);
        end
        reset_in = 1'b1;
        b0_raw = 1'b0;
        b1_raw = 1'b0;
        idle(15);
        finish_req = 1'b1;
        idle(5);
        $display("FAIL timeout: monitor did not finish");
        $fatal(1);
    end

endmodule
